// File: rtl/vector_writeback_buffer.sv
// vector_writeback_buffer: in-order result FIFO to the vector RF with bypass register and pending-tag lookup
module vector_writeback_buffer #(
  parameter int VLEN = 128,
  parameter int TAG_WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  input  logic [VLEN-1:0]            in_data,
  output logic                       in_ready,
  output logic                       rf_write_valid,
  output logic [TAG_WIDTH-1:0]       rf_write_tag,
  output logic [VLEN-1:0]            rf_write_data,
  input  logic                       rf_write_ready,
  output logic                       bypass_valid,
  output logic [TAG_WIDTH-1:0]       bypass_tag,
  output logic [VLEN-1:0]            bypass_data,
  input  logic [TAG_WIDTH-1:0]       query_tag,
  output logic                       query_hit,
  output logic [VLEN-1:0]            query_data,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);
  logic [TAG_WIDTH-1:0] mem_tag [DEPTH];
  logic [VLEN-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] head, tail, idx;
  logic [AW:0] count;
  logic push, pop;
  assign in_ready = count != FULL;
  assign rf_write_valid = count != '0;
  assign rf_write_tag = mem_tag[head];
  assign rf_write_data = mem_data[head];
  assign occupancy = count;
  assign push = in_valid && in_ready;
  assign pop = rf_write_valid && rf_write_ready;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
      bypass_valid <= 1'b0;
      bypass_tag <= '0;
      bypass_data <= '0;
    end else begin
      if (push) begin
        tail <= tail + PONE;
        vld[tail] <= 1'b1;
      end
      if (pop) begin
        head <= head + PONE;
        vld[head] <= 1'b0;
        bypass_valid <= 1'b1;
        bypass_tag <= mem_tag[head];
        bypass_data <= mem_data[head];
      end
      count <= (push && !pop) ? count + CONE : (pop && !push) ? count - CONE : count;
    end
  always_ff @(posedge clock)
    if (push) begin
      mem_tag[tail] <= in_tag;
      mem_data[tail] <= in_data;
    end
  // scan oldest to youngest so the last match wins
  always_comb begin
    query_hit = 1'b0;
    query_data = '0;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (vld[idx] && mem_tag[idx] == query_tag) begin
        query_hit = 1'b1;
        query_data = mem_data[idx];
      end
    end
  end
endmodule

// File: tb/tb_vector_writeback_buffer.sv
// tb_vector_writeback_buffer: table-driven and directed checks of the writeback buffer
module tb_vector_writeback_buffer;
  localparam int VLEN = 128, TW = 5, DEPTH = 4;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, rf_write_ready = 1'b0;
  logic [TW-1:0] in_tag = '0, query_tag = '0;
  logic [VLEN-1:0] in_data = '0;
  logic in_ready, rf_write_valid, bypass_valid, query_hit;
  logic [TW-1:0] rf_write_tag, bypass_tag;
  logic [VLEN-1:0] rf_write_data, bypass_data, query_data;
  logic [$clog2(DEPTH):0] occupancy;
  int n_chk = 0, n_fail = 0;

  vector_writeback_buffer #(.VLEN(VLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data), .in_ready(in_ready),
    .rf_write_valid(rf_write_valid), .rf_write_tag(rf_write_tag), .rf_write_data(rf_write_data),
    .rf_write_ready(rf_write_ready),
    .bypass_valid(bypass_valid), .bypass_tag(bypass_tag), .bypass_data(bypass_data),
    .query_tag(query_tag), .query_hit(query_hit), .query_data(query_data),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int iv, t, b, rdy, q;
    int rfv, rt, rb, inr, occ;
    int bpv, bt, bb, hit, qb;
  } vec_t;
  vec_t tbl [14];

  function automatic logic [VLEN-1:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent, got, over;
    tbl[0]  = '{1,1,'h11,0,1, 0,0,0,1,0, 0,0,0,0,0};
    tbl[1]  = '{1,2,'h22,0,1, 1,1,'h11,1,1, 0,0,0,1,'h11};
    tbl[2]  = '{1,1,'h33,0,1, 1,1,'h11,1,2, 0,0,0,1,'h11};
    tbl[3]  = '{1,4,'h44,0,1, 1,1,'h11,1,3, 0,0,0,1,'h33};
    tbl[4]  = '{1,5,'h55,0,5, 1,1,'h11,0,4, 0,0,0,0,0};
    tbl[5]  = '{1,5,'h55,1,1, 1,1,'h11,0,4, 0,0,0,1,'h33};
    tbl[6]  = '{0,0,0,1,1, 1,2,'h22,1,3, 1,1,'h11,1,'h33};
    tbl[7]  = '{1,6,'h66,1,2, 1,1,'h33,1,2, 1,2,'h22,0,0};
    tbl[8]  = '{0,0,0,0,6, 1,4,'h44,1,2, 1,1,'h33,1,'h66};
    tbl[9]  = '{0,0,0,1,4, 1,4,'h44,1,2, 1,1,'h33,1,'h44};
    tbl[10] = '{0,0,0,1,4, 1,6,'h66,1,1, 1,4,'h44,0,0};
    tbl[11] = '{0,0,0,1,6, 0,0,0,1,0, 1,6,'h66,0,0};
    tbl[12] = '{1,7,'h77,1,7, 0,0,0,1,0, 1,6,'h66,0,0};
    tbl[13] = '{0,0,0,1,7, 1,7,'h77,1,1, 1,6,'h66,1,'h77};

    repeat (2) @(posedge clock);
    #1;
    chk("reset in_ready", VLEN'(in_ready), VLEN'(1));
    chk("reset rf_write_valid", VLEN'(rf_write_valid), VLEN'(0));
    chk("reset bypass_valid", VLEN'(bypass_valid), VLEN'(0));
    chk("reset bypass_tag", VLEN'(bypass_tag), VLEN'(0));
    chk("reset bypass_data", bypass_data, VLEN'(0));
    chk("reset occupancy", VLEN'(occupancy), VLEN'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].iv[0];
      in_tag = TW'(tbl[i].t);
      in_data = pat(8'(tbl[i].b));
      rf_write_ready = tbl[i].rdy[0];
      query_tag = TW'(tbl[i].q);
      #1;
      chk($sformatf("v%0d rf_write_valid", i), VLEN'(rf_write_valid), VLEN'(tbl[i].rfv));
      if (tbl[i].rfv != 0) begin
        chk($sformatf("v%0d rf_write_tag", i), VLEN'(rf_write_tag), VLEN'(tbl[i].rt));
        chk($sformatf("v%0d rf_write_data", i), rf_write_data, pat(8'(tbl[i].rb)));
      end
      chk($sformatf("v%0d in_ready", i), VLEN'(in_ready), VLEN'(tbl[i].inr));
      chk($sformatf("v%0d occupancy", i), VLEN'(occupancy), VLEN'(tbl[i].occ));
      chk($sformatf("v%0d bypass_valid", i), VLEN'(bypass_valid), VLEN'(tbl[i].bpv));
      chk($sformatf("v%0d bypass_tag", i), VLEN'(bypass_tag), VLEN'(tbl[i].bt));
      chk($sformatf("v%0d bypass_data", i), bypass_data, pat(8'(tbl[i].bb)));
      chk($sformatf("v%0d query_hit", i), VLEN'(query_hit), VLEN'(tbl[i].hit));
      chk($sformatf("v%0d query_data", i), query_data, pat(8'(tbl[i].qb)));
      tick();
    end

    in_valid = 1'b1; in_tag = 5'd7; in_data = pat(8'h55); rf_write_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall rf_write_valid", VLEN'(rf_write_valid), VLEN'(1));
      chk("stall rf_write_tag", VLEN'(rf_write_tag), VLEN'(7));
      chk("stall rf_write_data", rf_write_data, pat(8'h55));
      tick();
    end
    rf_write_ready = 1'b1;
    tick();
    rf_write_ready = 1'b0;
    #1;
    chk("pulse occupancy", VLEN'(occupancy), VLEN'(0));
    chk("pulse rf_write_valid", VLEN'(rf_write_valid), VLEN'(0));
    chk("pulse bypass_tag", VLEN'(bypass_tag), VLEN'(7));
    chk("pulse bypass_data", bypass_data, pat(8'h55));
    tick();

    sent = 0; got = 0; over = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      in_valid = sent < 10;
      in_tag = TW'(10 + sent);
      in_data = pat(8'(10 + sent));
      rf_write_ready = (c % 2) == 0;
      #1;
      if (occupancy > 3'(DEPTH)) over++;
      if (rf_write_valid && rf_write_ready) begin
        chk("stream tag", VLEN'(rf_write_tag), VLEN'(10 + got));
        chk("stream data", rf_write_data, pat(8'(10 + got)));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("stream commits", VLEN'(got), VLEN'(10));
    chk("stream occupancy bound", VLEN'(over), VLEN'(0));

    rf_write_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_tag = TW'(k); in_data = pat(8'(k));
      tick();
    end
    in_valid = 1'b0;
    chk("pre-reset occupancy", VLEN'(occupancy), VLEN'(3));
    #3 reset = 1'b1;
    #1;
    chk("async reset rf_write_valid", VLEN'(rf_write_valid), VLEN'(0));
    chk("async reset occupancy", VLEN'(occupancy), VLEN'(0));
    chk("async reset in_ready", VLEN'(in_ready), VLEN'(1));
    chk("async reset bypass_valid", VLEN'(bypass_valid), VLEN'(0));
    chk("async reset bypass_tag", VLEN'(bypass_tag), VLEN'(0));
    chk("async reset bypass_data", bypass_data, VLEN'(0));
    #2 reset = 1'b0;
    rf_write_ready = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("post-reset rf_write_valid", VLEN'(rf_write_valid), VLEN'(0));
      tick();
    end
    in_valid = 1'b1; in_tag = 5'd9; in_data = pat(8'h99); rf_write_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("post-reset push valid", VLEN'(rf_write_valid), VLEN'(1));
    chk("post-reset push tag", VLEN'(rf_write_tag), VLEN'(9));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_writeback_buffer.md
Name: vector_writeback_buffer

Overview:
- Stage directly downstream of vector execution: captures each execution result packet (destination tag + VLEN data) into an in-order FIFO and drains it to the vector register file write port under a valid/ready handshake.
- Registers the most recently committed write and drives it as the bypass packet fed back into execution's bypass network.
- Provides a combinational pending-tag lookup so issue logic can stall on, or forward from, results not yet committed.

Parameters:
- VLEN, 128, data width of one vector register.
- TAG_WIDTH, 5, destination register tag width (32 vector registers).
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  execution result valid.
- in_tag  input  TAG_WIDTH  result destination tag.
- in_data  input  VLEN  result data.
- in_ready  output  1  buffer can accept; equals !full.
- rf_write_valid  output  1  head entry presented to register file.
- rf_write_tag  output  TAG_WIDTH  head entry tag.
- rf_write_data  output  VLEN  head entry data.
- rf_write_ready  input  1  register file accepts this cycle.
- bypass_valid  output  1  bypass packet holds a committed write.
- bypass_tag  output  TAG_WIDTH  last committed tag.
- bypass_data  output  VLEN  last committed data.
- query_tag  input  TAG_WIDTH  tag probed by issue logic.
- query_hit  output  1  some valid entry has tag == query_tag.
- query_data  output  VLEN  data of youngest matching entry; 0 when no hit.
- occupancy  output  $clog2(DEPTH)+1  valid entry count.

Behaviour:
- Interface: one clock "clock"; reset "reset" is asynchronous, active-high.
- Reset: clears pointers, count, entry valid bits and bypass registers. in_ready=1, rf_write_valid=0, bypass_valid=0, bypass_tag=0, bypass_data=0, occupancy=0. Reset asserted mid-operation discards all buffered entries; they are never written.
- Push: occurs when in_valid && in_ready. The entry is written at the tail and the tail pointer increments, wrapping modulo DEPTH.
- Pop: occurs when rf_write_valid && rf_write_ready. The head pointer increments, wrapping modulo DEPTH.
- Latency: a packet pushed in cycle N appears on rf_write_* in cycle N+1 at the earliest. There is no combinational in-to-out path.
- rf_write_* is driven from the head entry. rf_write_valid = (occupancy != 0).
- While rf_write_valid=1 and rf_write_ready=0, the head tag and data hold stable.
- Full: occupancy == DEPTH forces in_ready=0. in_ready does not depend on rf_write_ready, so there is no pop-through when full; in_valid is ignored.
- Empty: rf_write_valid=0. rf_write_tag and rf_write_data are don't-care; drive the head entry contents.
- Simultaneous push and pop with 0 < occupancy < DEPTH: both happen and occupancy is unchanged.
- Simultaneous push and pop when empty cannot occur, because pop requires occupancy > 0.
- Ordering: strictly FIFO. Same-tag entries commit in arrival order.
- Bypass: on each pop, bypass_valid<=1, bypass_tag<=head tag and bypass_data<=head data, visible the cycle after commit. Registers hold until the next pop; they are not cleared when the FIFO empties.
- Query: purely combinational over valid entries only.
  - query_hit=1 if any valid entry tag matches.
  - query_data selects the youngest match, i.e. the match closest to the tail, scanning with wrap-around from head.
  - An entry popped in the current cycle still counts as valid for the query in that cycle.
  - A push in the current cycle is not visible until the next cycle.
- occupancy counts from 0 to DEPTH inclusive and never wraps.

Test Plan:
- Single pass: after reset, push tag=3, data=0xA5 repeated, with rf_write_ready=1 → rf_write_valid=1, tag=3 in the next cycle. One cycle later bypass_valid=1, bypass_tag=3, bypass_data=0xA5.., and occupancy returns to 0.
- Fill and back-pressure: rf_write_ready=0, push tags 1,2,3,4 → occupancy=4 and in_ready=0; a 5th push (tag 5) is dropped. Raise ready → commits in order 1,2,3,4; tag 5 never appears.
- Stall stability: head tag=7, data=0x55.. with rf_write_ready=0 for 5 cycles → rf_write_tag and rf_write_data constant. Ready pulse for 1 cycle → exactly one commit.
- Wrap and simultaneous: stream 10 packets with in_valid=1 and rf_write_ready alternating 1/0 → all 10 commit in order, pointers wrap twice, and occupancy never exceeds DEPTH.
- Query youngest: buffered tag 2 with data=0x11.. then tag 2 with data=0x22.. → query_tag=2 gives hit=1, data=0x22... query_tag=9 gives hit=0, data=0.
- Async reset mid-stream: assert reset between clock edges with 3 entries buffered → outputs return to reset values immediately; no further rf_write_valid appears until a new push.
